// File: rtl/dsp_ram_arbiter.sv
// Display RAM port-A arbiter: Z80 writes beat screen-clear writes, which beat host accesses.
// All RAM port signals and host/clear status outputs come straight from registers.
module dsp_ram_arbiter #(
  parameter int unsigned RD_LAT   = 2,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       z80_wr,
  input  logic [9:0] z80_addr,
  input  logic [7:0] z80_data,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [9:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  input  logic       clr_start,
  output logic       clr_busy,
  output logic       clr_done,
  output logic       ram_en,
  output logic       ram_we,
  output logic [9:0] ram_addr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, CLEAR, HOST_RD} state_t;

  localparam logic [7:0] LAT_LAST = 8'(RD_LAT);

  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [7:0] lat_q, lat_d;
  logic       en_q, en_d;
  logic       we_q, we_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic       ack_q, ack_d;
  logic [7:0] rdata_q, rdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // The port output registers double as the Z80 holding register: a z80_wr
  // is captured into them at the strobe edge and appears on the port next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    done_d  = 1'b0;

    if (z80_wr) begin
      en_d   = 1'b1;
      we_d   = 1'b1;
      addr_d = z80_addr;
      din_d  = z80_data;
    end

    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (host_req && !ack_q && !z80_wr) begin
          en_d   = 1'b1;
          we_d   = host_we;
          addr_d = host_addr;
          din_d  = host_wdata;
          if (host_we) begin
            ack_d = 1'b1;
          end else begin
            state_d = HOST_RD;
            lat_d   = '0;
          end
        end
      end
      CLEAR: begin
        if (!z80_wr) begin
          en_d   = 1'b1;
          we_d   = 1'b1;
          addr_d = cnt_q;
          din_d  = CLR_CHAR;
          cnt_d  = cnt_q + 10'd1;
          if (cnt_q == '1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      HOST_RD: begin
        // lat_q is 0 in the cycle the read address is on the port
        if (lat_q == LAT_LAST) begin
          rdata_d = ram_dout;
          ack_d   = 1'b1;
          state_d = IDLE;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ram_en     = en_q;
  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_din    = din_q;
  assign host_ack   = ack_q;
  assign host_rdata = rdata_q;
  assign clr_busy   = busy_q;
  assign clr_done   = done_q;

endmodule

// File: tb/tb_dsp_ram_arbiter.sv
// Directed bench for dsp_ram_arbiter with a behavioural 2-cycle-latency RAM on port A.
module tb_dsp_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       z80_wr;
  logic [9:0] z80_addr;
  logic [7:0] z80_data;
  logic       host_req, host_we;
  logic [9:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       clr_start, clr_busy, clr_done;
  logic       ram_en, ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  logic [7:0] mem [1024];
  logic [7:0] p1, p2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dsp_ram_arbiter #(.RD_LAT(2), .CLR_CHAR(8'h20)) dut (
    .clk(clk), .reset(reset),
    .z80_wr(z80_wr), .z80_addr(z80_addr), .z80_data(z80_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // RAM model: address sampled at the edge ending the issue cycle, data valid 2 cycles after issue.
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_din;
    p1 <= mem[ram_addr];
    p2 <= p1;
  end
  assign ram_dout = p2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, done_at, n;
    reset = 1'b1; z80_wr = 1'b0; z80_addr = '0; z80_data = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; clr_start = 1'b0;
    tick();
    z80_wr = 1'b1; z80_addr = 10'h3C3; z80_data = 8'hEE;
    tick();
    reset = 1'b0; z80_wr = 1'b0;
    tick();
    chk("rst_en", {ram_en, ram_we}, 0);
    chk("rst_addr_din", {ram_addr, ram_din}, 0);
    chk("rst_status", {host_ack, clr_busy, clr_done}, 0);
    chk("rst_rdata", host_rdata, 0);

    // Single Z80 write appears exactly one cycle after the strobe
    z80_wr = 1'b1; z80_addr = 10'h123; z80_data = 8'h41;
    tick();
    z80_wr = 1'b0;
    chk("z80_en_we", {ram_en, ram_we}, 2'b11);
    chk("z80_addr", ram_addr, 10'h123);
    chk("z80_din", ram_din, 8'h41);
    tick();
    chk("z80_one_cycle", ram_en, 0);

    // Full clear, no other traffic
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("clr_busy_rise", {clr_busy, ram_en}, 2'b10);
    bad = 0; done_at = -1;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (!(ram_en && ram_we && ram_addr == 10'(i) && ram_din == 8'h20)) bad++;
      if (clr_done && done_at < 0) done_at = i;
      if (i < 1023 && !clr_busy) bad++;
      if (i == 1023 && clr_busy) bad++;
    end
    chk("clr_seq_bad", bad, 0);
    chk("clr_done_idx", done_at, 1023);
    tick();
    chk("clr_after", {clr_busy, clr_done, ram_en}, 0);
    chk("clr_over_z80", mem[10'h123], 8'h20);

    // Z80 write below the counter during a clear stalls the clear by one cycle
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 1;
    for (int i = 0; i < 10'h200; i++) begin tick(); n++; end
    z80_wr = 1'b1; z80_addr = 10'h005; z80_data = 8'hAB;
    tick(); n++;
    z80_wr = 1'b0;
    chk("clr_z80_issue", {ram_we, ram_addr, ram_din}, {1'b1, 10'h005, 8'hAB});
    tick(); n++;
    chk("clr_stall_addr", {ram_addr, ram_din}, {10'h200, 8'h20});
    while (!clr_done && n < 2000) begin tick(); n++; end
    chk("clr_stall_len", n, 1026);
    chk("clr_z80_persist", mem[10'h005], 8'hAB);
    chk("clr_neighbour", mem[10'h006], 8'h20);

    // Host read colliding with a Z80 write to the same address
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h3FF;
    z80_wr = 1'b1; z80_addr = 10'h3FF; z80_data = 8'h5A;
    tick();
    z80_wr = 1'b0;
    chk("hr_z80_first", {ram_en, ram_we, ram_addr, ram_din}, {2'b11, 10'h3FF, 8'h5A});
    tick();
    chk("hr_issue", {ram_en, ram_we, ram_addr}, {2'b10, 10'h3FF});
    z80_wr = 1'b1; z80_addr = 10'h3FF; z80_data = 8'h77;
    tick();
    z80_wr = 1'b0;
    n = 1;
    while (!host_ack && n < 10) begin tick(); n++; end
    chk("hr_ack_lat", n, 3);
    chk("hr_rdata", host_rdata, 8'h5A);
    tick();
    host_req = 1'b0;
    chk("hr_no_reservice", {ram_en, host_ack}, 0);
    chk("hr_rdata_hold", host_rdata, 8'h5A);
    chk("hr_later_z80", mem[10'h3FF], 8'h77);

    // Host write held off by a clear that starts in the same cycle
    clr_start = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h0AA; host_wdata = 8'hC3;
    tick();
    clr_start = 1'b0;
    chk("hw_clr_wins", {clr_busy, ram_en}, 2'b10);
    n = 0; bad = 0;
    while (!clr_done && n < 2000) begin
      tick(); n++;
      if (host_ack || ram_din == 8'hC3) bad++;
    end
    chk("hw_wait_len", n, 1024);
    chk("hw_wait_clean", bad, 0);
    tick();
    chk("hw_issue", {ram_en, ram_we, ram_addr, ram_din, host_ack}, {2'b11, 10'h0AA, 8'hC3, 1'b1});
    host_req = 1'b0;
    tick();
    chk("hw_ack_pulse", {host_ack, ram_en}, 0);
    chk("hw_mem", mem[10'h0AA], 8'hC3);

    // Reset in the middle of a clear, then restart
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 10'h080; i++) tick();
    chk("mid_clr_addr", ram_addr, 10'h07F);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_outs", {ram_en, ram_we, ram_addr, ram_din, host_ack, clr_busy, clr_done}, 0);
    chk("rst2_rdata", host_rdata, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (clr_done || clr_busy || ram_en) bad++;
    end
    chk("rst2_quiet", bad, 0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    chk("restart_addr0", {ram_en, ram_we, ram_addr, ram_din}, {2'b11, 10'h000, 8'h20});
    n = 0;
    while (!clr_done && n < 2000) begin
      if (n == 10) clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      n++;
    end
    chk("restart_len", n, 1023);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
